// File: rtl/wbuf_pkg.sv
// wbuf_pkg: shared types and constants for the data write buffer.
//   - WBUF_DEPTH   : default store-buffer entry count
//   - SIZE_*       : access size encodings (byte/half/word)
//   - state_e      : downstream transaction FSM states
//   - wbuf_entry_t : one buffered store {size, wstrb, addr, wdata}
package wbuf_pkg;

    localparam int unsigned WBUF_DEPTH = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = 4;
    localparam int unsigned SIZE_W     = 2;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_WAIT = 2'd1,
        LD_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } wbuf_entry_t;

    // True when two byte addresses fall in the same 32-bit word.
    function automatic logic same_word(input logic [ADDR_W-1:0] a,
                                       input logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:2] == b[ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// wbuf_fifo: circular store-entry storage for the data write buffer.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   push, push_entry  : enqueue one store (caller guarantees space, allowing push on pop)
//   pop               : drop the head entry (caller guarantees non-empty)
//   head              : oldest entry, all-zero payload after reset
//   full, empty       : occupancy flags
//   match_addr, match : per-slot flag, valid entry in the same word as match_addr
module wbuf_fifo
    import wbuf_pkg::*;
#(
    parameter int unsigned DEPTH = WBUF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  wbuf_entry_t       push_entry,
    input  logic              pop,
    input  logic [ADDR_W-1:0] match_addr,
    output wbuf_entry_t       head,
    output logic              full,
    output logic              empty,
    output logic [DEPTH-1:0]  match
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wbuf_entry_t      ent_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] off;

    // Storage, pointers and count; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            if (push) begin
                ent_q[wr_ptr] <= push_entry;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = ent_q[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A slot is valid when its distance from the read pointer is below count.
    always_comb begin
        match = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PTR_W'(i) - rd_ptr;
            match[i] = (CNT_W'(off) < count) && same_word(ent_q[i].addr, match_addr);
        end
    end

endmodule

// File: rtl/data_wbuf.sv
// data_wbuf: posted-store write buffer between the core and the memory bridge.
// Stores are accepted immediately into a DEPTH-entry FIFO and acknowledged one
// cycle later; the buffer drains them in order, one downstream transaction at
// a time. Loads go straight through when they cannot hit a buffered store.
// Build option: LOAD_BYPASS_EN -- when defined, a load may overtake buffered
// stores to other words; otherwise a load waits for the buffer to empty.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   cpu_req/wr/size/wstrb/addr/wdata, cpu_addr_ok/data_ok/rdata : core side (slave)
//   mem_req/wr/size/wstrb/addr/wdata, mem_addr_ok/data_ok/rdata : bridge side (master)
module data_wbuf
    import wbuf_pkg::*;
#(
    parameter int unsigned DEPTH = WBUF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [SIZE_W-1:0] cpu_size,
    input  logic [STRB_W-1:0] cpu_wstrb,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_addr_ok,
    output logic              cpu_data_ok,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [SIZE_W-1:0] mem_size,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e           state;
    logic             st_ack;
    wbuf_entry_t      head;
    wbuf_entry_t      push_entry;
    logic             full;
    logic             empty;
    logic [DEPTH-1:0] match;
    logic             pop;
    logic             st_acc;
    logic             ld_elig;
    logic             load_go;
    logic             drain_go;

    assign push_entry = '{size: cpu_size, wstrb: cpu_wstrb, addr: cpu_addr, wdata: cpu_wdata};

    wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (st_acc),
        .push_entry (push_entry),
        .pop        (pop),
        .match_addr (cpu_addr),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .match      (match)
    );

`ifdef LOAD_BYPASS_EN
    // Load may overtake buffered stores as long as none targets its word.
    assign ld_elig = ~(|match);
`else
    // An empty buffer never reports a match; the term keeps the hazard view uniform.
    assign ld_elig = empty & ~(|match);
`endif

    // Head retires when its downstream store completes.
    assign pop = (state == ST_WAIT) & mem_data_ok;

    // A full buffer still takes a store in the cycle its head retires.
    assign st_acc = ~reset & cpu_req & cpu_wr & (~full | pop) & (state != LD_WAIT);

    assign load_go  = ~reset & (state == IDLE) & ~st_ack & cpu_req & ~cpu_wr & ld_elig;
    assign drain_go = ~reset & (state == IDLE) & ~load_go & ~empty;

    assign cpu_addr_ok = st_acc | (load_go & mem_addr_ok);
    assign cpu_data_ok = st_ack | ((state == LD_WAIT) & mem_data_ok);
    assign cpu_rdata   = (state == LD_WAIT) ? mem_rdata : '0;

    // Downstream drive: the pending load wins, otherwise the head entry.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b1;
        mem_size  = head.size;
        mem_wstrb = head.wstrb;
        mem_addr  = head.addr;
        mem_wdata = head.wdata;
        if (load_go) begin
            mem_req   = 1'b1;
            mem_wr    = 1'b0;
            mem_size  = cpu_size;
            mem_wstrb = cpu_wstrb;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (drain_go) begin
            mem_req = 1'b1;
        end
    end

    // Transaction FSM and store acknowledge register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            st_ack <= 1'b0;
        end else begin
            st_ack <= st_acc;
            case (state)
                IDLE: begin
                    if (load_go && mem_addr_ok) begin
                        state <= LD_WAIT;
                    end else if (drain_go && mem_addr_ok) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_data_ok) begin
                        state <= IDLE;
                    end
                end
                LD_WAIT: begin
                    if (mem_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
